// File: rtl/rect_layer_pkg.sv
// Shared field encodings, rectangle record and default sizing for rect_layer_gen.
// The optional motion feature of rectangle 0 is enabled by defining BOUNCE_EN.
package rect_layer_pkg;

  localparam int N_RECT_DEF   = 4;
  localparam int XW_DEF       = 10;
  localparam int CW_DEF       = 8;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int VW           = 4;

  typedef enum logic [1:0] {
    FLD_XB  = 2'd0,
    FLD_YB  = 2'd1,
    FLD_COL = 2'd2,
    FLD_CTL = 2'd3
  } fld_e;

  typedef struct packed {
    logic [XW_DEF-1:0]     left;
    logic [XW_DEF-1:0]     right;
    logic [XW_DEF-1:0]     top;
    logic [XW_DEF-1:0]     bottom;
    logic [3*CW_DEF-1:0]   colour;
    logic                  enable;
    logic signed [VW-1:0]  vx;
    logic signed [VW-1:0]  vy;
  } rect_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rect_hit.sv
// Inclusive, unsigned bounds test of one pixel against one rectangle.
// An inverted box (left > right or top > bottom) can never satisfy both compares.
module rect_hit #(
  parameter int XW = 10
) (
  input  logic [XW-1:0] x,
  input  logic [XW-1:0] y,
  input  logic [XW-1:0] left,
  input  logic [XW-1:0] right,
  input  logic [XW-1:0] top,
  input  logic [XW-1:0] bottom,
  input  logic          enable,
  output logic          hit
);

  assign hit = enable && (x >= left) && (x <= right) && (y >= top) && (y <= bottom);

endmodule

// File: rtl/rect_layer_gen.sv
// Rectangle-layer generator: shadow/active register banks, frame-synchronous commit and a
// 2-cycle hit/colour pipeline. Define BOUNCE_EN to let rectangle 0 move and reflect each frame.
module rect_layer_gen
  import rect_layer_pkg::*;
#(
  parameter int N_RECT   = N_RECT_DEF,
  parameter int XW       = XW_DEF,
  parameter int CW       = CW_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  localparam int IW      = (N_RECT > 1) ? $clog2(N_RECT) : 1,
  localparam int DW      = max_int(2 * XW, 3 * CW)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] x,
  input  logic [XW-1:0] y,
  input  logic          video_on,
  input  logic          frame_tick,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [IW-1:0] wr_idx,
  input  logic [1:0]    wr_field,
  input  logic [DW-1:0] wr_data,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b,
  output logic          pix_valid
);

  if (N_RECT < 1 || N_RECT > 16) begin : g_bad_count
    $error("rect_layer_gen: N_RECT must be 1..16");
  end
  if (H_ACTIVE > (1 << XW) || V_ACTIVE > (1 << XW)) begin : g_bad_geometry
    $error("rect_layer_gen: active area does not fit in XW bits");
  end

  typedef struct packed {
    logic [XW-1:0]        left;
    logic [XW-1:0]        right;
    logic [XW-1:0]        top;
    logic [XW-1:0]        bottom;
    logic [3*CW-1:0]      colour;
    logic                 enable;
`ifdef BOUNCE_EN
    logic signed [VW-1:0] vx;
    logic signed [VW-1:0] vy;
`endif
  } rect_w_t;

  localparam logic [IW:0] N_LIM = (IW + 1)'(N_RECT);

  rect_w_t shadow [N_RECT];
  rect_w_t active [N_RECT];

  logic idx_ok;
  logic wr_en;

  assign wr_ready = !reset && !frame_tick;
  assign idx_ok   = ({1'b0, wr_idx} < N_LIM);
  assign wr_en    = wr_valid && wr_ready && idx_ok;

`ifdef BOUNCE_EN
  localparam logic signed [XW:0] X_MAX = (XW + 1)'(H_ACTIVE - 1);
  localparam logic signed [XW:0] Y_MAX = (XW + 1)'(V_ACTIVE - 1);

  logic             dirty;
  rect_w_t          moved0;
  logic signed [XW:0] nl;
  logic signed [XW:0] nr;
  logic signed [XW:0] nt;
  logic signed [XW:0] nb;

  function automatic logic signed [XW:0] step_pos(input logic [XW-1:0] p,
                                                  input logic signed [VW-1:0] v);
    return $signed({1'b0, p}) + $signed({{(XW + 1 - VW){v[VW-1]}}, v});
  endfunction

  // Next-frame position of rectangle 0; an axis that would leave the screen holds and reverses.
  always_comb begin
    moved0 = active[0];
    nl     = step_pos(active[0].left,   active[0].vx);
    nr     = step_pos(active[0].right,  active[0].vx);
    nt     = step_pos(active[0].top,    active[0].vy);
    nb     = step_pos(active[0].bottom, active[0].vy);
    if (nl[XW] || (nr > X_MAX)) begin
      moved0.vx = -active[0].vx;
    end else begin
      moved0.left  = nl[XW-1:0];
      moved0.right = nr[XW-1:0];
    end
    if (nt[XW] || (nb > Y_MAX)) begin
      moved0.vy = -active[0].vy;
    end else begin
      moved0.top    = nt[XW-1:0];
      moved0.bottom = nb[XW-1:0];
    end
  end
`endif

  // Writes are never accepted on the commit cycle, so the two branches cannot collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_RECT; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
`ifdef BOUNCE_EN
      dirty <= 1'b0;
`endif
    end else if (frame_tick) begin
      for (int i = 0; i < N_RECT; i++) begin
        active[i] <= shadow[i];
      end
`ifdef BOUNCE_EN
      dirty <= 1'b0;
      if (!dirty) begin
        active[0]    <= moved0;
        shadow[0].vx <= moved0.vx;
        shadow[0].vy <= moved0.vy;
      end
`endif
    end else if (wr_en) begin
      case (wr_field)
        FLD_XB: begin
          shadow[wr_idx].left  <= wr_data[XW-1:0];
          shadow[wr_idx].right <= wr_data[2*XW-1:XW];
        end
        FLD_YB: begin
          shadow[wr_idx].top    <= wr_data[XW-1:0];
          shadow[wr_idx].bottom <= wr_data[2*XW-1:XW];
        end
        FLD_COL: shadow[wr_idx].colour <= wr_data[3*CW-1:0];
        default: begin
          shadow[wr_idx].enable <= wr_data[0];
`ifdef BOUNCE_EN
          shadow[wr_idx].vx <= wr_data[7:4];
          shadow[wr_idx].vy <= wr_data[11:8];
`endif
        end
      endcase
`ifdef BOUNCE_EN
      if (wr_idx == '0) dirty <= 1'b1;
`endif
    end
  end

  logic [N_RECT-1:0] hit;

  for (genvar gi = 0; gi < N_RECT; gi++) begin : g_hit
    rect_hit #(
      .XW(XW)
    ) u_hit (
      .x      (x),
      .y      (y),
      .left   (active[gi].left),
      .right  (active[gi].right),
      .top    (active[gi].top),
      .bottom (active[gi].bottom),
      .enable (active[gi].enable),
      .hit    (hit[gi])
    );
  end

  // Stage 1: per-rectangle hit vector and visibility.
  logic [N_RECT-1:0] hit_p1;
  logic              vld_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      hit_p1 <= hit;
      vld_p1 <= video_on;
    end
  end

  logic [3*CW-1:0] sel_col;

  always_comb begin
    sel_col = '0;
    for (int i = N_RECT - 1; i >= 0; i--) begin
      if (hit_p1[i]) sel_col = active[i].colour;
    end
  end

  // Stage 2: priority-selected colour, blanked outside the visible area.
  logic [3*CW-1:0] col_p2;
  logic            vld_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      col_p2 <= '0;
      vld_p2 <= 1'b0;
    end else begin
      col_p2 <= (vld_p1 && (|hit_p1)) ? sel_col : '0;
      vld_p2 <= vld_p1;
    end
  end

  assign r         = col_p2[3*CW-1:2*CW];
  assign g         = col_p2[2*CW-1:CW];
  assign b         = col_p2[CW-1:0];
  assign pix_valid = vld_p2;

endmodule
